// File: rtl/hamming_rx_deserializer.sv
// Hamming(7,4) receive front-end: serial-to-codeword framing
// plus a show-ahead FIFO with valid/ready output.
module hamming_rx_deserializer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       bit_in,
    input  logic                       bit_valid,
    input  logic                       frame_start,
    output logic [6:0]                 code_out,
    output logic                       code_valid,
    input  logic                       code_ready,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow,
    input  logic                       clear_overflow,
    output logic                       resync
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {HUNT, SHIFT} state_t;

    state_t          state;
    logic [5:0]      sr;
    logic [2:0]      bc;
    logic [6:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    logic            realign;
    logic            push;
    logic            pop;
    logic            accept;
    logic [6:0]      word;
    logic [CW-1:0]   count_nx;

    always_comb begin
        realign = bit_valid && (state == SHIFT) && frame_start && (bc != 3'd0);
        push    = bit_valid && (state == SHIFT) && !frame_start && (bc == 3'd6);
        word    = {sr, bit_in};
        pop     = code_valid && code_ready;
        // A full FIFO still takes the word when the head leaves this cycle
        accept  = push && ((fifo_count != FULL) || pop);
        count_nx = fifo_count;
        if (accept && !pop)
            count_nx = fifo_count + 1'b1;
        else if (!accept && pop)
            count_nx = fifo_count - 1'b1;
    end

    assign code_out = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            sr         <= '0;
            bc         <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            code_valid <= 1'b0;
            overflow   <= 1'b0;
            resync     <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            resync <= realign;
            if (bit_valid) begin
                case (state)
                    HUNT: begin
                        if (frame_start) begin
                            sr    <= {5'b0, bit_in};
                            bc    <= 3'd1;
                            state <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (realign) begin
                            sr <= {5'b0, bit_in};
                            bc <= 3'd1;
                        end else if (bc == 3'd6) begin
                            sr <= {sr[4:0], bit_in};
                            bc <= 3'd0;
                        end else begin
                            sr <= {sr[4:0], bit_in};
                            bc <= bc + 3'd1;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end

            if (accept) begin
                mem[wr_ptr] <= word;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= count_nx;
            code_valid <= (count_nx != '0);

            if (push && !accept)
                overflow <= 1'b1;
            else if (clear_overflow)
                overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_hamming_rx_deserializer.sv
// Directed bench for hamming_rx_deserializer: framing, FIFO,
// overflow and asynchronous reset behaviour.
module tb_hamming_rx_deserializer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       frame_start = 1'b0;
    logic [6:0] code_out;
    logic       code_valid;
    logic       code_ready = 1'b0;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       clear_overflow = 1'b0;
    logic       resync;

    int tests = 0;
    int fails = 0;
    logic [6:0] got_q[$];
    int resync_cnt = 0;

    always #5 clk = ~clk;

    hamming_rx_deserializer #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in),
        .bit_valid(bit_valid), .frame_start(frame_start),
        .code_out(code_out), .code_valid(code_valid),
        .code_ready(code_ready), .fifo_count(fifo_count),
        .overflow(overflow), .clear_overflow(clear_overflow),
        .resync(resync)
    );

    // Record every handshake and resync pulse seen at a rising edge
    always @(posedge clk) begin
        if (rst_n && code_valid && code_ready)
            got_q.push_back(code_out);
        if (rst_n && resync)
            resync_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input logic fs);
        @(negedge clk);
        bit_in      = b;
        bit_valid   = 1'b1;
        frame_start = fs;
        @(posedge clk);
        #1;
        bit_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic send_word(input logic [6:0] w, input logic fs,
                             input int max_gap);
        logic [6:0] v;
        v = w;
        for (int i = 6; i >= 0; i--) begin
            if (max_gap > 0)
                idle($urandom_range(0, max_gap));
            send_bit(v[i], fs && (i == 6));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        got_q.delete();
        resync_cnt = 0;
    endtask

    task automatic check_q(input string tag, input logic [6:0] exp[$]);
        check({tag, "_n"}, got_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got_q.size(); i++)
            check(tag, got_q[i], exp[i]);
    endtask

    initial begin
        logic [6:0] w;
        do_reset();
        check("rst_valid", code_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_resync", resync, 0);
        check("rst_code", code_out, 7'h00);

        // Single word 0x55 with latency check
        code_ready = 1'b1;
        w = 7'h55;
        for (int i = 6; i >= 1; i--)
            send_bit(w[i], i == 6);
        check("pre7_valid", code_valid, 0);
        send_bit(w[0], 1'b0);
        check("lat_valid", code_valid, 1);
        check("lat_code", code_out, 7'h55);
        check("lat_count", fifo_count, 1);
        idle(1);
        check("pop_valid", code_valid, 0);
        check("pop_count", fifo_count, 0);
        idle(2);
        check_q("single", '{7'h55});

        // Back-to-back with gaps, no second frame_start
        got_q.delete();
        resync_cnt = 0;
        send_word(7'h55, 1'b1, 2);
        send_word(7'h0F, 1'b0, 2);
        idle(3);
        check_q("b2b", '{7'h55, 7'h0F});
        check("b2b_resync", resync_cnt, 0);

        // Bits in HUNT ignored; realignment after 4 bits
        do_reset();
        code_ready = 1'b1;
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        idle(2);
        check("hunt_count", fifo_count, 0);
        check("hunt_valid", code_valid, 0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        check("resync_hi", resync, 1);
        send_bit(1'b1, 1'b0);
        check("resync_lo", resync, 0);
        for (int i = 0; i < 5; i++)
            send_bit(1'b1, 1'b0);
        idle(3);
        check_q("realign", '{7'h7F});
        check("resync_cnt", resync_cnt, 1);

        // Overflow with stalled consumer
        do_reset();
        code_ready = 1'b0;
        for (int k = 1; k <= 5; k++)
            send_word(7'(k), k == 1, 0);
        idle(1);
        check("ovf_count", fifo_count, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_head", code_out, 7'h01);
        code_ready = 1'b1;
        idle(6);
        code_ready = 1'b0;
        check_q("drain", '{7'h01, 7'h02, 7'h03, 7'h04});
        check("drain_count", fifo_count, 0);
        check("ovf_sticky", overflow, 1);
        @(negedge clk);
        clear_overflow = 1'b1;
        @(posedge clk);
        #1;
        clear_overflow = 1'b0;
        check("ovf_clear", overflow, 0);

        // Full FIFO, pop on the cycle the 5th word completes
        do_reset();
        code_ready = 1'b0;
        send_word(7'h11, 1'b1, 0);
        send_word(7'h22, 1'b0, 0);
        send_word(7'h33, 1'b0, 0);
        send_word(7'h44, 1'b0, 0);
        check("full_count", fifo_count, 4);
        w = 7'h55;
        for (int i = 6; i >= 1; i--)
            send_bit(w[i], 1'b0);
        @(negedge clk);
        code_ready  = 1'b1;
        bit_in      = w[0];
        bit_valid   = 1'b1;
        @(posedge clk);
        #1;
        bit_valid   = 1'b0;
        code_ready  = 1'b0;
        check("same_count", fifo_count, 4);
        check("same_ovf", overflow, 0);
        check("same_head", code_out, 7'h22);
        code_ready = 1'b1;
        idle(6);
        check_q("same", '{7'h11, 7'h22, 7'h33, 7'h44, 7'h55});

        // Asynchronous reset mid-word with 2 words buffered
        do_reset();
        code_ready = 1'b0;
        send_word(7'h3C, 1'b1, 0);
        send_word(7'h5A, 1'b0, 0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        check("pre_arst_count", fifo_count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", code_valid, 0);
        check("arst_count", fifo_count, 0);
        check("arst_ovf", overflow, 0);
        check("arst_resync", resync, 0);
        check("arst_code", code_out, 7'h00);
        @(negedge clk);
        rst_n = 1'b1;
        got_q.delete();
        resync_cnt = 0;
        code_ready = 1'b1;
        send_word(7'h2A, 1'b1, 0);
        idle(3);
        check_q("post_arst", '{7'h2A});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
